ysyx_25020042_wb_arb: RTL and testbench
=======================================

# ysyx_25020042_wb_arb

Write-back arbiter and register scoreboard for the single GPR write port. It arbitrates two write-back requesters (EXU results and LSU load data) onto the `rd`/`data_in` port of the 32-entry GPR using round-robin. It also tracks pending destination registers so that decode can stall on RAW/WAW hazards. It sits between EXU/LSU and the GPR, and exports a stall to IDU.

## Interface
- `REG_ADDR_LEN`, 5: register index width.
- `WIDTH`, 32: data width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `exu_valid`  in  1  EXU write-back request.
- `exu_ready`  out  1  EXU request accepted this cycle.
- `exu_rd`  in  REG_ADDR_LEN  EXU destination.
- `exu_data`  in  WIDTH  EXU result.
- `lsu_valid`, `lsu_ready`, `lsu_rd`, `lsu_data`: same as the EXU group, for the LSU requester.
- `id_valid`  in  1  IDU presents an instruction for issue.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR_LEN  source and destination indices of the presented instruction.
- `id_stall`  out  1  issue blocked this cycle.
- `gpr_rd`  out  REG_ADDR_LEN  to GPR `rd`; 0 when idle.
- `gpr_wdata`  out  WIDTH  to GPR `data_in`.
- `busy`  out  32  scoreboard bit vector; bit 0 is always 0.
- `wb_err`  out  1  sticky: a write was accepted to a non-busy register.

## Operation
- **Ordering:** the GPR writes on every edge where `rd != 0`. The block therefore drives `gpr_rd = 0` on every cycle without a committed write.
- **Arbitration:**
  - Only one request is accepted per cycle.
  - If exactly one of `exu_valid`/`lsu_valid` is high, that requester is granted.
  - If both are high, the requester not granted most recently wins. The `last_grant` register updates on every grant.
  - `*_ready` is combinational from the valids and `last_grant`; it never depends on `*_ready` of the other side.
- **Handshake:**
  - Acceptance is `valid & ready`.
  - A requester holds valid, rd and data stable until accepted.
  - Dropping valid before acceptance is legal and has no effect.
- **Commit stage:**
  - On acceptance, {rd, data} are registered into `gpr_rd`/`gpr_wdata` for exactly one cycle.
  - The next cycle they return to 0 unless another acceptance occurred.
- **rd = 0 requests:** accepted normally, commit nothing, and leave the scoreboard and `wb_err` unchanged.
- **Scoreboard set:** on `id_valid & !id_stall & id_rd != 0`, `busy[id_rd]` is set.
- **Scoreboard clear:** the bit is cleared on the same edge that the GPR samples the committed write, i.e. when `gpr_rd != 0`, `busy[gpr_rd]` is cleared.
- **Stall:** `id_stall = id_valid & (busy[id_rs1] | busy[id_rs2] | busy[id_rd])`.
  - Terms use the registered busy vector only; there is no bypass.
  - Index 0 never stalls.
- **Set and clear on the same register in one edge:** cannot occur, because `busy[id_rd]` already forces a stall. If a bench forces it anyway, set wins.
- **`wb_err`:** set when an accepted request with `rd != 0` targets a register whose busy bit is 0. It clears only on reset.

## Timing
- **Reset values (asynchronous, immediate on `rst = 0`):**
  - `busy = 0`, `gpr_rd = 0`, `gpr_wdata = 0`, `wb_err = 0`.
  - `last_grant = EXU`, so LSU wins the first tie.
  - The ready and stall outputs follow combinationally from the reset state.
- **Grant latency:** 0 cycles; ready is asserted in the request cycle.
- **Write latency:**
  - Handshake at edge N registers the commit.
  - `gpr_rd`/`gpr_wdata` are valid between edges N and N+1.
  - The GPR captures the value at edge N+1, and `busy` clears at that same edge.
  - A dependent instruction issues in the cycle after edge N+1, and its GPR read returns the new value.
- **Throughput:** one write per cycle sustained. Back-to-back commits produce consecutive non-zero `gpr_rd` cycles with no bubble.
- **Reset mid-operation:** in-flight commit and scoreboard state are discarded, with no partial write. Requesters must re-present after reset.

## Test plan
- **Reset:** assert `rst = 0` mid-commit with `gpr_rd = 5`. Required: `gpr_rd`, `gpr_wdata`, `busy` and `wb_err` all read 0 immediately; `lsu_ready = 1` on the first post-reset tie.
- **RAW:** issue `id_rd = 7`, then present `id_rs1 = 7`. Required: `id_stall = 1`. Then EXU writes rd 7 with data `0xDEADBEEF`: handshake at edge N, `gpr_rd = 7` in the next cycle, `busy[7] = 0` after edge N+1, `id_stall = 0`, and GPR x7 reads `0xDEADBEEF`.
- **Tie arbitration:**
  - Setup: mark rd 3 and rd 4 busy, then hold both requesters valid, EXU with rd 3 and LSU with rd 4.
  - Required: LSU is granted first, EXU next.
  - Then with rd 3, 4, 5, 6 all busy, hold both valid for 4 cycles. Required: grants alternate L, E, L, E, and `gpr_rd` sequences with no idle cycle.
- **x0:** EXU presents rd 0 with data `0x1234`. Required: accepted in 0 cycles, `gpr_rd` stays 0, `busy` and `wb_err` unchanged.
- **WAW and error:** issue `id_rd = 9` twice. Required: the second issue stalls until the LSU rd 9 commit completes. Then an EXU write to non-busy rd 12 is accepted. Required: `wb_err` rises and stays 1 until reset.

Source files
------------

// File: rtl/ysyx_25020042_wb_arb.sv
// Write-back arbiter for the single GPR write port.
// Round-robins EXU/LSU results and keeps the RAW/WAW scoreboard.
module ysyx_25020042_wb_arb #(
    parameter int REG_ADDR_LEN = 5,
    parameter int WIDTH        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exu_valid,
    output logic                    exu_ready,
    input  logic [REG_ADDR_LEN-1:0] exu_rd,
    input  logic [WIDTH-1:0]        exu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [REG_ADDR_LEN-1:0] lsu_rd,
    input  logic [WIDTH-1:0]        lsu_data,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_rs1,
    input  logic [REG_ADDR_LEN-1:0] id_rs2,
    input  logic [REG_ADDR_LEN-1:0] id_rd,
    output logic                    id_stall,
    output logic [REG_ADDR_LEN-1:0] gpr_rd,
    output logic [WIDTH-1:0]        gpr_wdata,
    output logic [31:0]             busy,
    output logic                    wb_err
);

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    grant_e                  last_grant_q, last_grant_d;
    logic [31:0]             busy_q, busy_d;
    logic [REG_ADDR_LEN-1:0] gpr_rd_q, gpr_rd_d;
    logic [WIDTH-1:0]        gpr_wdata_q, gpr_wdata_d;
    logic                    wb_err_q, wb_err_d;

    logic                    acc;
    logic [REG_ADDR_LEN-1:0] sel_rd;
    logic [WIDTH-1:0]        sel_data;
    logic                    issue;

    // On a tie the side not granted most recently wins.
    assign exu_ready = exu_valid & (~lsu_valid | (last_grant_q == GNT_LSU));
    assign lsu_ready = lsu_valid & (~exu_valid | (last_grant_q == GNT_EXU));
    assign acc       = exu_ready | lsu_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        unique case (1'b1)
            exu_ready: begin
                sel_rd   = exu_rd;
                sel_data = exu_data;
            end
            lsu_ready: begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
            end
            default: begin
                sel_rd   = '0;
                sel_data = '0;
            end
        endcase
    end

    assign id_stall = id_valid &
                      (busy_q[id_rs1] | busy_q[id_rs2] | busy_q[id_rd]);
    assign issue    = id_valid & ~id_stall & (id_rd != '0);

    always_comb begin
        last_grant_d = last_grant_q;
        if (exu_ready) last_grant_d = GNT_EXU;
        if (lsu_ready) last_grant_d = GNT_LSU;

        gpr_rd_d    = acc ? sel_rd : '0;
        gpr_wdata_d = (acc && sel_rd != '0) ? sel_data : '0;

        // Clear first so a same-edge set on that register wins.
        busy_d = busy_q;
        if (gpr_rd_q != '0) busy_d[gpr_rd_q] = 1'b0;
        if (issue)          busy_d[id_rd]    = 1'b1;
        busy_d[0] = 1'b0;

        wb_err_d = wb_err_q |
                   (acc & (sel_rd != '0) & ~busy_q[sel_rd]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GNT_EXU;
            busy_q       <= '0;
            gpr_rd_q     <= '0;
            gpr_wdata_q  <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            gpr_rd_q     <= gpr_rd_d;
            gpr_wdata_q  <= gpr_wdata_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign gpr_rd    = gpr_rd_q;
    assign gpr_wdata = gpr_wdata_q;
    assign busy      = busy_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_ysyx_25020042_wb_arb.sv
// Bench for ysyx_25020042_wb_arb: directed vectors, corner
// sequences and random traffic against a cycle-level model.
module tb_ysyx_25020042_wb_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exu_valid = 1'b0, lsu_valid = 1'b0, id_valid = 1'b0;
    logic        exu_ready, lsu_ready, id_stall, wb_err;
    logic [4:0]  exu_rd = '0, lsu_rd = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, gpr_rd;
    logic [31:0] exu_data = '0, lsu_data = '0, gpr_wdata, busy;

    int checks = 0;
    int errors = 0;

    ysyx_25020042_wb_arb #(.REG_ADDR_LEN(5), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_stall(id_stall),
        .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // The register file the arbiter feeds.
    logic [31:0] gpr_mem [32];
    always @(posedge clk)
        if (gpr_rd != 5'd0) gpr_mem[gpr_rd] <= gpr_wdata;

    // Reference model state.
    bit [31:0] m_busy;
    bit        m_last_lsu;
    bit        m_err;
    bit [4:0]  m_crd;
    bit [31:0] m_cdata;
    bit        m_er, m_lr, m_st;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_busy = '0; m_last_lsu = 1'b0; m_err = 1'b0;
        m_crd = '0; m_cdata = '0;
    endfunction

    function automatic void m_comb();
        if (exu_valid && lsu_valid) begin
            m_lr = !m_last_lsu;
            m_er = m_last_lsu;
        end else begin
            m_er = exu_valid;
            m_lr = lsu_valid;
        end
        m_st = id_valid && (m_busy[id_rs1] || m_busy[id_rs2] ||
                            m_busy[id_rd]);
    endfunction

    function automatic void m_edge();
        bit [31:0] b0;
        bit [4:0]  ard;
        bit [31:0] adat;
        bit        acc;
        b0 = m_busy;
        if (m_crd != 0) m_busy[m_crd] = 1'b0;
        if (id_valid && !m_st && id_rd != 0) m_busy[id_rd] = 1'b1;
        acc  = m_er || m_lr;
        ard  = m_er ? exu_rd : lsu_rd;
        adat = m_er ? exu_data : lsu_data;
        if (acc && ard != 0 && !b0[ard]) m_err = 1'b1;
        m_crd   = acc ? ard : 5'd0;
        m_cdata = (acc && ard != 0) ? adat : 32'd0;
        if (m_er) m_last_lsu = 1'b0;
        if (m_lr) m_last_lsu = 1'b1;
    endfunction

    // Check everything against the model, then take one edge.
    task automatic step();
        #1;
        m_comb();
        chk("exu_ready", exu_ready, m_er);
        chk("lsu_ready", lsu_ready, m_lr);
        chk("id_stall", id_stall, m_st);
        chk("gpr_rd", gpr_rd, m_crd);
        chk("gpr_wdata", gpr_wdata, m_cdata);
        chk("busy", busy, m_busy);
        chk("wb_err", wb_err, m_err);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle_in();
        exu_valid = 0; lsu_valid = 0; id_valid = 0;
        exu_rd = 0; lsu_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        exu_data = 0; lsu_data = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        #1;
        chk("rst_gpr_rd", gpr_rd, 0);
        chk("rst_gpr_wdata", gpr_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb_err", wb_err, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        id_valid = 1; id_rd = r; id_rs1 = 0; id_rs2 = 0;
        step();
        id_valid = 0; id_rd = 0;
    endtask

    typedef struct {
        logic       ev;
        logic [4:0] erd;
        logic [31:0] edat;
        logic       lv;
        logic [4:0] lrd;
        logic [31:0] ldat;
        logic       iv;
        logic [4:0] rs1;
        logic [4:0] ird;
        logic       x_er;
        logic       x_lr;
        logic       x_st;
        logic [4:0] x_grd;
    } vec_t;

    vec_t vt [9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  e_list [2];
        logic [4:0]  l_list [3];
        logic [4:0]  seq [4];
        int ei, li;
        bit pe, pl;

        vt[0] = '{0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0};
        vt[1] = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0};
        vt[2] = '{1, 2, 32'hAA, 1, 0, 32'hBB, 1, 2, 0, 0, 1, 1, 0};
        vt[3] = '{1, 2, 32'hAA, 0, 0, 0, 1, 2, 0, 1, 0, 1, 0};
        vt[4] = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
        vt[5] = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0};
        vt[6] = '{1, 0, 32'h1, 1, 0, 32'h2, 0, 0, 0, 0, 1, 0, 0};
        vt[7] = '{1, 0, 32'h1, 1, 0, 32'h2, 0, 0, 0, 1, 0, 0, 0};
        vt[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        m_reset();
        idle_in();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a commit of rd 5.
        issue(5);
        exu_valid = 1; exu_rd = 5; exu_data = 32'h55;
        step();
        exu_valid = 0;
        #1 chk("mid_commit_rd", gpr_rd, 5);
        do_reset();
        exu_valid = 1; lsu_valid = 1;
        #1 chk("post_rst_tie_lsu", lsu_ready, 1);
        chk("post_rst_tie_exu", exu_ready, 0);
        step();
        idle_in();
        step();

        // RAW on x7.
        issue(7);
        id_valid = 1; id_rs1 = 7;
        #1 chk("raw_stall", id_stall, 1);
        exu_valid = 1; exu_rd = 7; exu_data = 32'hDEADBEEF;
        step();
        exu_valid = 0;
        #1 chk("raw_commit_rd", gpr_rd, 7);
        chk("raw_commit_data", gpr_wdata, 32'hDEADBEEF);
        chk("raw_stall_n", id_stall, 1);
        step();
        chk("raw_busy7", busy[7], 0);
        chk("raw_unstall", id_stall, 0);
        chk("raw_gpr_x7", gpr_mem[7], 32'hDEADBEEF);
        step();
        idle_in();

        // Tie: LSU then EXU.
        issue(3);
        issue(4);
        exu_valid = 1; exu_rd = 3; exu_data = 32'h33;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
        #1 chk("tie1_lsu", lsu_ready, 1);
        chk("tie1_exu", exu_ready, 0);
        step();
        lsu_valid = 0;
        #1 chk("tie2_exu", exu_ready, 1);
        chk("tie2_rd", gpr_rd, 4);
        step();
        exu_valid = 0;
        #1 chk("tie3_rd", gpr_rd, 3);
        step();

        // Sustained alternation with no bubble.
        issue(3); issue(4); issue(5); issue(6);
        e_list[0] = 3; e_list[1] = 5;
        l_list[0] = 4; l_list[1] = 6; l_list[2] = 6;
        seq[0] = 4; seq[1] = 3; seq[2] = 6; seq[3] = 5;
        ei = 0; li = 0;
        for (int i = 0; i < 4; i++) begin
            exu_valid = 1; exu_rd = e_list[ei];
            exu_data = 32'h100 + 32'(ei);
            lsu_valid = 1; lsu_rd = l_list[li];
            lsu_data = 32'h200 + 32'(li);
            #1;
            chk("alt_lsu", lsu_ready, (i % 2) == 0);
            chk("alt_exu", exu_ready, (i % 2) == 1);
            if (i > 0) chk("alt_rd", gpr_rd, seq[i-1]);
            if ((i % 2) == 0) li++;
            else ei++;
            step();
        end
        idle_in();
        #1 chk("alt_rd_last", gpr_rd, seq[3]);
        step();

        // Write to x0.
        exu_valid = 1; exu_rd = 0; exu_data = 32'h1234;
        #1 chk("x0_ready", exu_ready, 1);
        step();
        exu_valid = 0;
        #1 chk("x0_rd", gpr_rd, 0);
        chk("x0_err", wb_err, 0);
        step();

        // WAW on x9, then an unmatched write to x12.
        issue(9);
        id_valid = 1; id_rd = 9;
        #1 chk("waw_stall", id_stall, 1);
        step();
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
        step();
        lsu_valid = 0;
        #1 chk("waw_stall_n", id_stall, 1);
        step();
        chk("waw_unstall", id_stall, 0);
        step();
        idle_in();
        exu_valid = 1; exu_rd = 12; exu_data = 32'hC;
        #1 chk("err_ready", exu_ready, 1);
        step();
        exu_valid = 0;
        chk("err_set", wb_err, 1);
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", wb_err, 1);

        // Directed vector table from a clean reset.
        do_reset();
        foreach (vt[i]) begin
            exu_valid = vt[i].ev; exu_rd = vt[i].erd;
            exu_data = vt[i].edat;
            lsu_valid = vt[i].lv; lsu_rd = vt[i].lrd;
            lsu_data = vt[i].ldat;
            id_valid = vt[i].iv; id_rs1 = vt[i].rs1;
            id_rs2 = 0; id_rd = vt[i].ird;
            #1;
            chk($sformatf("vec%0d_er", i), exu_ready, vt[i].x_er);
            chk($sformatf("vec%0d_lr", i), lsu_ready, vt[i].x_lr);
            chk($sformatf("vec%0d_st", i), id_stall, vt[i].x_st);
            chk($sformatf("vec%0d_rd", i), gpr_rd, vt[i].x_grd);
            step();
        end

        // Random traffic against the model.
        do_reset();
        pe = 0; pl = 0;
        for (int n = 0; n < 600; n++) begin
            if (!exu_valid || pe) begin
                exu_valid = 1'($urandom_range(0, 1));
                exu_rd = 5'($urandom_range(0, 7));
                exu_data = $urandom;
            end else if ($urandom_range(0, 9) == 0) exu_valid = 0;
            if (!lsu_valid || pl) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd = 5'($urandom_range(0, 7));
                lsu_data = $urandom;
            end else if ($urandom_range(0, 9) == 0) lsu_valid = 0;
            id_valid = 1'($urandom_range(0, 1));
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            step();
            pe = m_er;
            pl = m_lr;
        end
        idle_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
